// File: rtl/ariane_pkg.sv
// Shared fetch-path types and helpers for the frontend realigner and scanners.
package ariane_pkg;

  localparam int unsigned FETCH_WIDTH      = 32;
  localparam int unsigned INSTR_PER_FETCH  = 2;
  localparam int unsigned FETCH_ADDR_WIDTH = 64;

  typedef struct packed {
    logic [FETCH_ADDR_WIDTH-1:0] addr;
    logic [FETCH_WIDTH-1:0]      instr;
  } fetch_entry_t;

  // Which halfword begins the first output slot of a fetch word.
  typedef enum logic [1:0] {
    SRC_CARRY,
    SRC_LOWER,
    SRC_UPPER
  } fetch_src_e;

  function automatic logic is_rvc(input logic [15:0] half);
    return half[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/fetch_realigner.sv
// Splits 32-bit fetch words into up to two aligned instructions, carrying the
// lower half of a 32-bit instruction that straddles a fetch-word boundary.
module fetch_realigner
  import ariane_pkg::*;
#(
  parameter int unsigned VLEN = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic                      ready_i,
  input  logic [VLEN-1:0]           address_i,
  input  logic [31:0]               data_i,
  output logic [1:0]                valid_o,
  output logic [1:0][31:0]          instr_o,
  output logic [1:0][VLEN-1:0]      addr_o,
  output logic                      serving_unaligned_o
);

  logic            unaligned_q, unaligned_d;
  logic [15:0]     unaligned_instr_q, unaligned_instr_d;
  logic [VLEN-1:0] unaligned_addr_q, unaligned_addr_d;

  fetch_entry_t [INSTR_PER_FETCH-1:0] slot;
  logic [INSTR_PER_FETCH-1:0]         slot_valid;

  logic            fire, contiguous, use_upper, upper_slot;
  logic [15:0]     lower_half, upper_half;
  logic [VLEN-1:0] upper_addr;
  fetch_src_e      src;

  assign fire       = valid_i & ready_i & ~flush_i;
  assign lower_half = data_i[15:0];
  assign upper_half = data_i[31:16];
  assign upper_addr = {address_i[VLEN-1:2], 2'b00} + VLEN'(2);
  assign contiguous = unaligned_q && (address_i == unaligned_addr_q + VLEN'(2));

  always_comb begin
    if (contiguous)        src = SRC_CARRY;
    else if (!address_i[1]) src = SRC_LOWER;
    else                   src = SRC_UPPER;
  end

  always_comb begin
    slot              = '0;
    slot_valid        = '0;
    use_upper         = 1'b0;
    upper_slot        = 1'b0;
    unaligned_d       = flush_i ? 1'b0 : unaligned_q;
    unaligned_instr_d = unaligned_instr_q;
    unaligned_addr_d  = unaligned_addr_q;

    if (fire) begin
      unaligned_d = 1'b0;
      use_upper   = 1'b1;
      unique case (src)
        SRC_CARRY: begin
          slot[0].instr = {lower_half, unaligned_instr_q};
          slot[0].addr  = FETCH_ADDR_WIDTH'(unaligned_addr_q);
          slot_valid[0] = 1'b1;
          upper_slot    = 1'b1;
        end
        SRC_LOWER: begin
          slot_valid[0] = 1'b1;
          slot[0].addr  = FETCH_ADDR_WIDTH'(address_i);
          if (is_rvc(lower_half)) begin
            slot[0].instr = {16'h0000, lower_half};
            upper_slot    = 1'b1;
          end else begin
            slot[0].instr = data_i;
            use_upper     = 1'b0;
          end
        end
        SRC_UPPER: upper_slot = 1'b0;
        default: ;
      endcase

      // A non-compressed upper half is never emitted here; it waits for its
      // second half in the next contiguous fetch word.
      if (use_upper) begin
        if (is_rvc(upper_half)) begin
          slot[upper_slot].instr = {16'h0000, upper_half};
          slot[upper_slot].addr  = FETCH_ADDR_WIDTH'(upper_addr);
          slot_valid[upper_slot] = 1'b1;
        end else begin
          unaligned_d       = 1'b1;
          unaligned_instr_d = upper_half;
          unaligned_addr_d  = upper_addr;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      unaligned_q       <= 1'b0;
      unaligned_instr_q <= '0;
      unaligned_addr_q  <= '0;
    end else begin
      unaligned_q       <= unaligned_d;
      unaligned_instr_q <= unaligned_instr_d;
      unaligned_addr_q  <= unaligned_addr_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < INSTR_PER_FETCH; i++) begin
      instr_o[i] = slot[i].instr;
      addr_o[i]  = slot[i].addr[VLEN-1:0];
    end
  end

  assign valid_o             = slot_valid;
  assign ready_o             = ready_i;
  assign serving_unaligned_o = unaligned_q;

endmodule

// File: tb/tb_fetch_realigner.sv
// Randomised scoreboard bench for fetch_realigner against a halfword-stream model.
module tb_fetch_realigner;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic             flush_i, valid_i, ready_i;
  logic             ready_o, serving_unaligned_o;
  logic [63:0]      address_i;
  logic [31:0]      data_i;
  logic [1:0]       valid_o;
  logic [1:0][31:0] instr_o;
  logic [1:0][63:0] addr_o;

  fetch_realigner #(.VLEN(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .valid_i(valid_i),
    .ready_o(ready_o), .ready_i(ready_i), .address_i(address_i), .data_i(data_i),
    .valid_o(valid_o), .instr_o(instr_o), .addr_o(addr_o),
    .serving_unaligned_o(serving_unaligned_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]       v;
    logic [1:0][31:0] i;
    logic [1:0][63:0] a;
    logic             serv;
    logic             rdy;
  } exp_t;

  typedef struct {
    logic [15:0] h;
    logic [63:0] a;
  } hw_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  logic        m_held  = 1'b0;
  logic [15:0] m_half  = '0;
  logic [63:0] m_haddr = '0;

  // Reference: the word becomes a stream of halfwords (held half first), and
  // instructions are peeled off in order; a lone trailing 32-bit half is held.
  task automatic model(input logic v, r, f, input logic [63:0] a,
                       input logic [31:0] d, output exp_t e);
    hw_t         q[$];
    hw_t         x, y;
    logic [63:0] base;
    int          n;
    e      = '0;
    e.serv = m_held;
    e.rdy  = r;
    if (v && r && !f) begin
      base = {a[63:2], 2'b00};
      if (m_held && a == m_haddr + 64'd2) q.push_back('{m_half, m_haddr});
      if (!a[1]) q.push_back('{d[15:0], base});
      q.push_back('{d[31:16], base + 64'd2});
      m_held = 1'b0;
      n = 0;
      while (q.size() > 0) begin
        x = q.pop_front();
        if (x.h[1:0] != 2'b11) begin
          e.v[n] = 1'b1; e.i[n] = {16'h0000, x.h}; e.a[n] = x.a; n++;
        end else if (q.size() > 0) begin
          y = q.pop_front();
          e.v[n] = 1'b1; e.i[n] = {y.h, x.h}; e.a[n] = x.a; n++;
        end else begin
          m_held = 1'b1; m_half = x.h; m_haddr = x.a;
        end
      end
    end else if (f) begin
      m_held = 1'b0;
    end
  endtask

  task automatic drive(input logic v, r, f, input logic [63:0] a, input logic [31:0] d);
    exp_t e;
    @(posedge clk_i); #1;
    rst_ni = 1'b1; valid_i = v; ready_i = r; flush_i = f;
    address_i = {a[63:1], 1'b0}; data_i = d;
    model(v, r, f, {a[63:1], 1'b0}, d, e);
    sbq.push_back(e);
  endtask

  task automatic do_reset();
    exp_t e;
    @(posedge clk_i); #1;
    rst_ni = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
    m_held = 1'b0;
    e = '0; e.rdy = 1'b1;
    sbq.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp_v, $time);
    end
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("valid_o", 64'(valid_o), 64'(e.v));
      check("serving_unaligned_o", 64'(serving_unaligned_o), 64'(e.serv));
      check("ready_o", 64'(ready_o), 64'(e.rdy));
      for (int s = 0; s < 2; s++) begin
        if (e.v[s]) begin
          check(s == 0 ? "slot0 instr" : "slot1 instr", 64'(instr_o[s]), 64'(e.i[s]));
          check(s == 0 ? "slot0 addr"  : "slot1 addr",  addr_o[s], e.a[s]);
        end
      end
    end
  end

  logic [63:0] cur_addr;
  logic [31:0] cur_data;
  logic        fired;

  function automatic logic [15:0] rand_half();
    logic [15:0] h;
    h = 16'($urandom);
    if ($urandom_range(1) == 1) h[1:0] = 2'b11;
    return h;
  endfunction

  initial begin
    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1; flush_i = 1'b0;
    address_i = '0; data_i = '0;
    do_reset();
    do_reset();

    drive(1, 1, 0, 64'h1000, 32'h0000_0013);
    drive(1, 1, 0, 64'h1000, 32'h4505_0001);
    drive(1, 1, 0, 64'h1000, 32'h0513_0001);
    drive(1, 1, 0, 64'h1004, 32'h0001_0000);
    drive(1, 1, 0, 64'h2002, 32'h8082_1234);
    drive(1, 1, 0, 64'h2002, 32'h0513_abcd);
    drive(1, 1, 1, 64'h2004, 32'h0001_0001);
    drive(0, 1, 0, 64'h2004, 32'h0001_0001);
    drive(1, 1, 0, 64'h1000, 32'h0513_0001);
    for (int k = 0; k < 3; k++) drive(1, 0, 0, 64'h1004, 32'h0001_0000);
    drive(1, 1, 0, 64'h1004, 32'h0001_0000);
    drive(1, 1, 0, 64'h1000, 32'h0513_0001);
    drive(1, 1, 0, 64'h3000, 32'h0000_0013);
    drive(1, 1, 0, 64'h1000, 32'h0513_0001);
    do_reset();
    drive(1, 1, 0, 64'h1004, 32'h0001_0000);
    drive(1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 32'h0513_0001);
    drive(1, 1, 0, 64'h0, 32'h4505_0001);

    cur_addr = 64'h4000; cur_data = {rand_half(), rand_half()}; fired = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      logic v, r, f;
      v = ($urandom_range(99) < 85);
      r = ($urandom_range(99) < 80);
      f = ($urandom_range(99) < 6);
      if (fired || $urandom_range(4) == 0) begin
        if ($urandom_range(99) < 75) cur_addr = {cur_addr[63:2], 2'b00} + 64'd4;
        else cur_addr = {32'h0, 16'h0, 4'($urandom), 10'($urandom), 1'($urandom), 1'b0};
        cur_data = {rand_half(), rand_half()};
      end
      if ($urandom_range(99) < 2) begin
        do_reset();
        fired = 1'b0;
      end else begin
        drive(v, r, f, cur_addr, cur_data);
        fired = v && r && !f;
      end
    end

    @(posedge clk_i); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk_i);
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard drain: %0d pending, expected 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_realigner.md
# fetch_realigner

Sits between the instruction cache fetch port and the per-slot instruction scanners. It splits each 32-bit fetch word into up to two naturally aligned instructions, compressed or not, with their addresses. It carries the lower half of a 32-bit instruction that straddles a fetch-word boundary over to the next fetch word. Every valid output slot delivers exactly the "aligned instruction, compressed or not" that each scanner expects.

## Interface
Parameters:
- VLEN, 64, virtual address width

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  asynchronous active-low reset
- flush_i  input  1  discard carried half-instruction (branch redirect, exception, fence.i)
- valid_i  input  1  fetch word valid
- ready_o  output  1  fetch word accepted this cycle; equals ready_i
- ready_i  input  1  downstream instruction queue can take two instructions
- address_i  input  VLEN  fetch word address, bit 0 always 0; bit 1 set means entry at upper halfword
- data_i  input  32  fetch word, little-endian halfwords
- valid_o  output  2  per-slot instruction valid
- instr_o  output  2x32  per-slot instruction; compressed ones zero-extended in [31:16]
- addr_o  output  2xVLEN  per-slot instruction address
- serving_unaligned_o  output  1  a carried lower half is held (= unaligned_q)

## Operation
- State: unaligned_q (1b), unaligned_instr_q (16b), unaligned_addr_q (VLEN).
- Halfword h is RVC iff h[1:0] != 2'b11.
- fire = valid_i & ready_i & ~flush_i. Outputs are computed only when fire; otherwise valid_o = 0.
- contiguous = unaligned_q & (address_i == unaligned_addr_q + 2).
- Case A, contiguous:
  - slot0 = {data_i[15:0], unaligned_instr_q} at unaligned_addr_q.
  - Upper half data_i[31:16] is processed by rule U.
- Case B, not contiguous and address_i[1] == 0. A held half is silently dropped.
  - If data_i[15:0] is RVC: slot0 = {16'b0, data_i[15:0]} at address_i, then upper half by rule U.
  - Otherwise: slot0 = data_i at address_i, and slot1 is invalid.
- Case C, not contiguous and address_i[1] == 1: only data_i[31:16] is considered. It is evaluated by rule U, but placed in slot0.
- Rule U, upper half at address A+2 where A = {address_i[VLEN-1:2], 2'b00}:
  - If RVC: emit it as a zero-extended instruction in the next free slot.
  - Otherwise: capture it into unaligned_instr_q, set unaligned_addr_q = A+2 and unaligned_d = 1. No slot is emitted for it.
- Any fire whose rule U does not capture clears unaligned_d.
- Slots always fill in order: valid_o == 2'b10 never occurs.
- Address arithmetic is modulo 2^VLEN (wraps).

## Timing
- Outputs are combinational from the inputs and state: 0-cycle latency. State updates on the rising clk_i edge when fire.
- Reset, asynchronous:
  - unaligned_q = 0, unaligned_instr_q = 0, unaligned_addr_q = 0.
  - Hence serving_unaligned_o = 0, and valid_o = 0 unless fire.
- flush_i has priority over valid_i in the same cycle: outputs are invalid, the fetch word is dropped, and unaligned_q is cleared at the edge.
- valid_i & ~ready_i: outputs are invalid and state is held; upstream must present the same word again.
- Reset asserted mid-straddle discards the held half; no partial instruction is emitted afterwards.

## Structure
- ariane_pkg holds:
  - FETCH_WIDTH = 32 and INSTR_PER_FETCH = 2.
  - Function is_rvc(logic [15:0]).
  - fetch_entry_t {addr, instr}, used for the slot arrays.
- No sub-module. Instantiate one instr_scan per output slot outside this block, in the frontend.

## Test plan
- Aligned RVI: address 0x1000, data 0x00000013 -> valid_o = 01, slot0 = 0x00000013 @0x1000, serving_unaligned_o = 0.
- Two RVC: address 0x1000, data 0x4505_0001 -> valid_o = 11, slot0 = 0x0001 @0x1000, slot1 = 0x4505 @0x1002.
- Straddle:
  - Cycle 1: address 0x1000, data 0x0513_0001 -> valid_o = 01 (0x0001 @0x1000), serving_unaligned_o = 1 next cycle.
  - Cycle 2: address 0x1004, data 0x0001_0000 -> slot0 = 0x00000513 @0x1002, slot1 = 0x0001 @0x1006.
- Redirect into upper half: address 0x2002, data 0x8082_xxxx -> valid_o = 01, slot0 = 0x8082 @0x2002. Repeat with upper half 0x0513 -> valid_o = 00, held half captured.
- Flush/stall:
  - Hold a straddle, then assert flush_i together with valid_i -> valid_o = 00, serving_unaligned_o = 0 next cycle.
  - Separately: ready_i = 0 for 3 cycles -> valid_o = 00 and state unchanged.
- Discontiguous drop: hold a half @0x1002, then fetch 0x3000 with data 0x00000013 -> slot0 = 0x00000013 @0x3000 only, and the held half is discarded.
